// File: rtl/qspi_port_arbiter.sv
// Two-port word-access arbiter in front of one QSPI flash controller. Sequential
// words are streamed without repeating the command/address phase.
module qspi_port_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        qspi_enable,
    output logic        qspi_interruptOperation,
    output logic [23:0] qspi_address,
    output logic        qspi_changeAddress,
    output logic        qspi_requestData,
    output logic        qspi_storeData,
    output logic [31:0] qspi_writeData,
    input  logic [31:0] qspi_readData,
    input  logic        qspi_wordComplete,
    input  logic        qspi_initialised,
    input  logic        qspi_busy
);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ADDR, ST_WORD, ST_NEXT} state_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [21:0] addr_q, addr_d;
    logic        rr_last_q, rr_last_d;
    logic        stream_valid_q, stream_valid_d;
    logic        stream_we_q, stream_we_d;
    logic [21:0] next_addr_q, next_addr_d;
    logic [3:0]  burst_q, burst_d;
    logic        intr_done_q, intr_done_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        own_req, own_we, oth_req, gnt, gnt_we, reuse, cont;
    logic [21:0] own_addr, gnt_addr;
    logic [31:0] own_wdata;

    assign own_req   = owner_q ? p1_req : p0_req;
    assign own_we    = owner_q ? p1_we : p0_we;
    assign own_addr  = owner_q ? p1_addr[23:2] : p0_addr[23:2];
    assign own_wdata = owner_q ? p1_wdata : p0_wdata;
    assign oth_req   = owner_q ? p0_req : p1_req;

    // On a tie the port that did not win last time is granted.
    assign gnt      = (p0_req && p1_req) ? ~rr_last_q : p1_req;
    assign gnt_we   = gnt ? p1_we : p0_we;
    assign gnt_addr = gnt ? p1_addr[23:2] : p0_addr[23:2];

    assign reuse = stream_valid_q && (gnt_addr == next_addr_q) && (gnt_we == stream_we_q);
    assign cont  = own_req && (own_addr == next_addr_q) && (own_we == stream_we_q)
                   && (!oth_req || (burst_q < BURST_LIMIT));

    assign qspi_enable  = 1'b1;
    assign qspi_address = {addr_q, 2'b00};
    assign p0_ack       = ack0_q;
    assign p1_ack       = ack1_q;
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        we_d           = we_q;
        addr_d         = addr_q;
        rr_last_d      = rr_last_q;
        stream_valid_d = stream_valid_q;
        stream_we_d    = stream_we_q;
        next_addr_d    = next_addr_q;
        burst_d        = burst_q;
        intr_done_d    = intr_done_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        qspi_interruptOperation = 1'b0;
        qspi_changeAddress      = 1'b0;
        qspi_requestData        = 1'b0;
        qspi_storeData          = 1'b0;
        qspi_writeData          = 32'd0;

        unique case (state_q)
            ST_INIT: begin
                if (qspi_initialised) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    owner_d   = gnt;
                    we_d      = gnt_we;
                    addr_d    = gnt_addr;
                    rr_last_d = gnt;
                    burst_d   = 4'd0;
                    state_d   = reuse ? ST_WORD : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // An open controller stream must be aborted before re-addressing.
                if (stream_valid_q && qspi_busy && !intr_done_q) begin
                    qspi_interruptOperation = 1'b1;
                    intr_done_d             = 1'b1;
                end else begin
                    qspi_changeAddress = 1'b1;
                    qspi_storeData     = we_q;
                    intr_done_d        = 1'b0;
                    state_d            = ST_WORD;
                end
            end
            ST_WORD: begin
                qspi_requestData = ~we_q;
                qspi_storeData   = we_q;
                qspi_writeData   = we_q ? own_wdata : 32'd0;
                if (qspi_wordComplete) begin
                    ack0_d         = ~owner_q;
                    ack1_d         = owner_q;
                    if (!we_q && !owner_q) rdata0_d = qspi_readData;
                    if (!we_q && owner_q)  rdata1_d = qspi_readData;
                    next_addr_d    = addr_q + 22'd1;
                    stream_valid_d = 1'b1;
                    stream_we_d    = we_q;
                    burst_d        = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
                    state_d        = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (cont) begin
                    // Keep the stream strobes high so the controller never sees a gap.
                    qspi_requestData = ~we_q;
                    qspi_storeData   = we_q;
                    qspi_writeData   = we_q ? own_wdata : 32'd0;
                    addr_d           = own_addr;
                    state_d          = ST_WORD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Device re-initialisation kills any stream; the pending word is reissued later.
        if (!qspi_initialised) begin
            stream_valid_d          = 1'b0;
            intr_done_d             = 1'b0;
            ack0_d                  = 1'b0;
            ack1_d                  = 1'b0;
            rdata0_d                = rdata0_q;
            rdata1_d                = rdata1_q;
            qspi_interruptOperation = 1'b0;
            qspi_changeAddress      = 1'b0;
            qspi_requestData        = 1'b0;
            qspi_storeData          = 1'b0;
            qspi_writeData          = 32'd0;
            state_d                 = ST_INIT;
        end
    end

    // NOTE: state registers use non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            rr_last_q      <= 1'b1;
            stream_valid_q <= 1'b0;
            stream_we_q    <= 1'b0;
            next_addr_q    <= '0;
            burst_q        <= '0;
            intr_done_q    <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            rr_last_q      <= rr_last_d;
            stream_valid_q <= stream_valid_d;
            stream_we_q    <= stream_we_d;
            next_addr_q    <= next_addr_d;
            burst_q        <= burst_d;
            intr_done_q    <= intr_done_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_qspi_port_arbiter.sv
// Directed bench for qspi_port_arbiter with a small behavioural QSPI controller
// (4-cycle first word, 2-cycle streamed words, read data derived from the address).
module tb_qspi_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [23:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic        qspi_enable, qspi_interruptOperation, qspi_changeAddress;
    logic        qspi_requestData, qspi_storeData;
    logic [23:0] qspi_address;
    logic [31:0] qspi_writeData, qspi_readData;
    logic        qspi_wordComplete, qspi_initialised, qspi_busy;

    int total = 0;
    int bad   = 0;

    qspi_port_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .qspi_enable(qspi_enable), .qspi_interruptOperation(qspi_interruptOperation),
        .qspi_address(qspi_address), .qspi_changeAddress(qspi_changeAddress),
        .qspi_requestData(qspi_requestData), .qspi_storeData(qspi_storeData),
        .qspi_writeData(qspi_writeData), .qspi_readData(qspi_readData),
        .qspi_wordComplete(qspi_wordComplete), .qspi_initialised(qspi_initialised),
        .qspi_busy(qspi_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    // Controller model
    int          m_cnt, m_lat;
    logic [23:0] m_addr, m_store_addr;
    logic [31:0] m_store_data;
    logic        m_busy;

    assign qspi_busy = m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0; m_lat <= 4; m_addr <= '0; m_busy <= 1'b0;
            qspi_wordComplete <= 1'b0; qspi_readData <= '0;
            m_store_addr <= '0; m_store_data <= '0;
        end else begin
            qspi_wordComplete <= 1'b0;
            if (qspi_interruptOperation) m_busy <= 1'b0;
            if (qspi_changeAddress) begin
                m_addr <= qspi_address; m_cnt <= 0; m_lat <= 4; m_busy <= 1'b1;
            end else if ((qspi_requestData || qspi_storeData) && !qspi_wordComplete) begin
                if (m_cnt + 1 >= m_lat) begin
                    qspi_wordComplete <= 1'b1;
                    qspi_readData     <= word_of(m_addr);
                    if (qspi_storeData) begin
                        m_store_addr <= m_addr;
                        m_store_data <= qspi_writeData;
                    end
                    m_addr <= m_addr + 24'd4;
                    m_cnt  <= 0;
                    m_lat  <= 2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // Event monitors (sample the cycle's values at the closing edge)
    int          cyc = 0, chg_cnt = 0, intr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    int          last_chg_cyc = 0, last_intr_cyc = 0;
    logic [23:0] last_chg_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (qspi_changeAddress) begin
                chg_cnt <= chg_cnt + 1; last_chg_cyc <= cyc; last_chg_addr <= qspi_address;
            end
            if (qspi_interruptOperation) begin
                intr_cnt <= intr_cnt + 1; last_intr_cyc <= cyc;
            end
            if (p0_ack) ack0_cnt <= ack0_cnt + 1;
            if (p1_ack) ack1_cnt <= ack1_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int port, output logic [31:0] rd);
        logic seen = 1'b0;
        rd = '0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (port == 0 ? p0_ack : p1_ack) begin
                seen = 1'b1;
                rd   = (port == 0) ? p0_rdata : p1_rdata;
            end
        end
        check("ack_arrives", 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int c0, i0, a0, a1, n0;
        logic got1;
        logic [31:0] rd_last0;

        rst = 1'b1; qspi_initialised = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_enable", 32'(qspi_enable), 32'd1);
        check("reset_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        check("reset_strobes", {29'd0, qspi_changeAddress, qspi_requestData, qspi_storeData}, 32'd0);
        check("reset_intr", 32'(qspi_interruptOperation), 32'd0);
        check("reset_addr", 32'(qspi_address), 32'd0);
        check("reset_rdata", p0_rdata, 32'd0);

        // Requests held before the device is initialised
        rst = 1'b0;
        p0_req = 1; p0_addr = 24'h000300;
        p1_req = 1; p1_addr = 24'h000400;
        repeat (10) @(negedge clk);
        check("init_no_ack", 32'(ack0_cnt + ack1_cnt), 32'd0);
        check("init_no_chg", 32'(chg_cnt), 32'd0);
        check("init_no_req", 32'(qspi_requestData), 32'd0);
        qspi_initialised = 1'b1;
        for (int n = 0; n < 200 && !(p0_ack || p1_ack); n++) @(negedge clk);
        check("init_first_p0", {30'd0, p0_ack, p1_ack}, 32'd2);
        check("init_first_rd", p0_rdata, word_of(24'h000300));
        p0_req = 0;
        wait_ack(1, rd);
        p1_req = 0;
        check("init_p1_rd", rd, word_of(24'h000400));
        check("init_intr", 32'(intr_cnt), 32'd1);

        // Sequential reads share one stream
        c0 = chg_cnt; a0 = ack0_cnt;
        p0_req = 1; p0_addr = 24'h000100;
        wait_ack(0, rd); check("seq_rd0", rd, word_of(24'h000100));
        p0_addr = 24'h000104;
        wait_ack(0, rd); check("seq_rd1", rd, word_of(24'h000104));
        p0_addr = 24'h000108;
        wait_ack(0, rd); check("seq_rd2", rd, word_of(24'h000108));
        p0_req = 0;
        repeat (2) @(negedge clk);
        check("seq_one_chg", 32'(chg_cnt - c0), 32'd1);
        check("seq_acks", 32'(ack0_cnt - a0), 32'd3);

        // Non-sequential jump aborts the stream
        c0 = chg_cnt; i0 = intr_cnt;
        p0_req = 1; p0_addr = 24'h000100;
        wait_ack(0, rd); check("jump_rd0", rd, word_of(24'h000100));
        p0_addr = 24'h000200;
        wait_ack(0, rd); check("jump_rd1", rd, word_of(24'h000200));
        p0_req = 0;
        repeat (2) @(negedge clk);
        check("jump_intr", 32'(intr_cnt - i0), 32'd2);
        check("jump_chg", 32'(chg_cnt - c0), 32'd2);
        check("jump_chg_addr", 32'(last_chg_addr), 32'h000200);
        check("jump_intr_first", 32'(last_chg_cyc - last_intr_cyc), 32'd1);

        // Address wrap keeps the stream; low address bits are ignored
        c0 = chg_cnt;
        p0_req = 1; p0_addr = 24'hFFFFFC;
        wait_ack(0, rd); check("wrap_rd0", rd, word_of(24'hFFFFFC));
        p0_addr = 24'h000002;
        wait_ack(0, rd); check("wrap_rd1", rd, word_of(24'h000000));
        p0_req = 0;
        repeat (2) @(negedge clk);
        check("wrap_one_chg", 32'(chg_cnt - c0), 32'd1);

        // Burst limit: p0 streams 8 words, then p1 is granted
        p0_req = 1; p0_addr = 24'h001000;
        for (int n = 0; n < 50 && !qspi_changeAddress; n++) @(negedge clk);
        check("burst_p0_grant", {7'd0, qspi_changeAddress, qspi_address}, {8'd1, 24'h001000});
        p1_req = 1; p1_we = 0; p1_addr = 24'h002000;
        n0 = 0; got1 = 1'b0; rd = '0; rd_last0 = '0;
        for (int n = 0; n < 600 && !got1; n++) begin
            @(negedge clk);
            if (p0_ack) begin n0++; rd_last0 = p0_rdata; p0_addr = p0_addr + 24'd4; end
            if (p1_ack) begin got1 = 1'b1; rd = p1_rdata; end
        end
        p0_req = 0; p1_req = 0;
        check("burst_p1_acked", 32'(got1), 32'd1);
        check("burst_p0_words", 32'(n0), 32'd8);
        check("burst_p0_last_rd", rd_last0, word_of(24'h00101C));
        check("burst_p1_chg_addr", 32'(last_chg_addr), 32'h002000);
        check("burst_p1_rd", rd, word_of(24'h002000));

        // Write then read at the next address: direction change forces a new stream
        repeat (2) @(negedge clk);
        c0 = chg_cnt; a0 = ack0_cnt; a1 = ack1_cnt;
        p1_req = 1; p1_we = 1; p1_addr = 24'h000010; p1_wdata = 32'hDEADBEEF;
        wait_ack(1, rd);
        p1_req = 0; p1_we = 0;
        p0_req = 1; p0_we = 0; p0_addr = 24'h000014;
        wait_ack(0, rd);
        p0_req = 0;
        repeat (2) @(negedge clk);
        check("wr_rd_p0", rd, word_of(24'h000014));
        check("wr_store_data", m_store_data, 32'hDEADBEEF);
        check("wr_store_addr", 32'(m_store_addr), 32'h000010);
        check("wr_two_chg", 32'(chg_cnt - c0), 32'd2);
        check("wr_acks", {16'(ack0_cnt - a0), 16'(ack1_cnt - a1)}, {16'd1, 16'd1});

        // Device re-initialisation mid-word: no ack, request reissued afterwards
        a0 = ack0_cnt; i0 = intr_cnt;
        p0_req = 1; p0_addr = 24'h000600;
        for (int n = 0; n < 50 && !qspi_requestData; n++) @(negedge clk);
        qspi_initialised = 1'b0;
        repeat (6) @(negedge clk);
        check("reinit_no_ack", 32'(ack0_cnt - a0), 32'd0);
        check("reinit_no_req", 32'(qspi_requestData), 32'd0);
        qspi_initialised = 1'b1;
        i0 = intr_cnt;
        wait_ack(0, rd);
        p0_req = 0;
        check("reinit_rd", rd, word_of(24'h000600));
        check("reinit_no_intr", 32'(intr_cnt - i0), 32'd0);

        // Synchronous reset in the middle of a word
        repeat (2) @(negedge clk);
        p0_req = 1; p0_addr = 24'h000500;
        for (int n = 0; n < 50 && !qspi_requestData; n++) @(negedge clk);
        check("rst_in_word", 32'(qspi_requestData), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        check("rst_strobes", {30'd0, qspi_changeAddress, qspi_requestData}, 32'd0);
        check("rst_rdata", p0_rdata, 32'd0);
        rst = 1'b0;
        wait_ack(0, rd);
        p0_req = 0;
        check("rst_reissue_rd", rd, word_of(24'h000500));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
